// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B on N x N signed 8-bit matrices through one shared MAC.
// Walks elements row-major: CLEAR, N operand fetches, one drain cycle, then WRITE.
module matmul_ctrl #(
   parameter int N      = 3,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [7:0]        a_rdata,
   input  logic [7:0]        b_rdata,
   output logic              macc_clear,
   output logic [7:0]        mac_a,
   output logic [7:0]        mac_b,
   input  logic [18:0]       mac_out,
   output logic [ADDR_W-1:0] c_addr,
   output logic [18:0]       c_wdata,
   output logic              c_we
);

   // state   | meaning
   // IDLE    | waiting for start
   // CLEAR   | zero the MAC accumulator for the next element
   // FETCH   | issue A/B read addresses for k = 0..N-1
   // DRAIN   | last operand pair enters the MAC
   // WRITE   | store mac_out to C[i][j], advance j/i

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_DRAIN,
      S_WRITE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] i_q, j_q, k_q;
   logic [CW-1:0] i_nxt, j_nxt, k_nxt;
   logic          done_nxt;
   logic          rd_valid;

   function automatic logic [ADDR_W-1:0] lin(input logic [CW-1:0] row, input logic [CW-1:0] col);
      return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         i_q      <= i_nxt;
         j_q      <= j_nxt;
         k_q      <= k_nxt;
         rd_valid <= (state == S_FETCH);
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      i_nxt     = i_q;
      j_nxt     = j_q;
      k_nxt     = k_q;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_CLEAR;
               i_nxt     = '0;
               j_nxt     = '0;
               k_nxt     = '0;
            end
         end
         S_CLEAR: begin
            k_nxt     = '0;
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (k_q == LAST) begin
               k_nxt     = '0;
               state_nxt = S_DRAIN;
            end else begin
               k_nxt = k_q + 1'b1;
            end
         end
         S_DRAIN: state_nxt = S_WRITE;
         S_WRITE: begin
            state_nxt = S_CLEAR;
            if (j_q == LAST) begin
               j_nxt = '0;
               if (i_q == LAST) begin
                  i_nxt     = '0;
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  i_nxt = i_q + 1'b1;
               end
            end else begin
               j_nxt = j_q + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Zero operands outside the data-valid window so the MAC simply holds.
   always_comb begin
      busy       = (state != S_IDLE);
      macc_clear = (state == S_CLEAR);
      c_we       = (state == S_WRITE);
      a_addr     = '0;
      b_addr     = '0;
      c_addr     = '0;
      c_wdata    = '0;
      mac_a      = rd_valid ? a_rdata : 8'd0;
      mac_b      = rd_valid ? b_rdata : 8'd0;
      if (state == S_FETCH) begin
         a_addr = lin(i_q, k_q);
         b_addr = lin(k_q, j_q);
      end
      if (state == S_WRITE) begin
         c_addr  = lin(i_q, j_q);
         c_wdata = mac_out;
      end
   end

endmodule
